// File: rtl/gear_shift_ctrl_pkg.sv
// Shared gear codes and FSM state encoding for the shift controller and the display stage.
package gear_shift_ctrl_pkg;

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    typedef enum logic [2:0] {
        ST_P     = 3'd0,
        ST_R     = 3'd1,
        ST_N     = 3'd2,
        ST_D     = 3'd3,
        ST_SHIFT = 3'd4
    } gear_state_t;

    function automatic logic [3:0] gear_code(input gear_state_t s);
        case (s)
            ST_R:    gear_code = GEAR_R;
            ST_N:    gear_code = GEAR_N;
            ST_D:    gear_code = GEAR_D;
            default: gear_code = GEAR_P;
        endcase
    endfunction

endpackage

// File: rtl/gear_shift_ctrl_debounce.sv
// Button conditioner: 2-flop synchroniser, tick-based debounce counter, rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1ms,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt tracks consecutive samples that differ from the accepted level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            rise <= 1'b0;
            if (tick_1ms) begin
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt >= CW'(DEBOUNCE_MS - 1)) begin
                    level <= sync[1];
                    rise  <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gear_shift_ctrl.sv
// Gear selector FSM: debounced up/down requests, brake/speed interlocks, timed SHIFT state.
//
// state    | meaning
// ST_P     | park, gear_char=3
// ST_R     | reverse, gear_char=6
// ST_N     | neutral, gear_char=9
// ST_D     | drive, gear_char=12
// ST_SHIFT | shift in progress, old code shown, target latched
module gear_shift_ctrl
    import gear_shift_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int SHIFT_MS    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       brake,
    input  logic [7:0] speed,
    output logic [3:0] gear_char,
    output logic       shift_busy,
    output logic       shift_reject
);

    localparam int SW = $clog2(SHIFT_MS + 1);

    logic          up_req;
    logic          dn_req;
    gear_state_t   state;
    gear_state_t   target;
    gear_state_t   next_gear;
    logic          shift_ok;
    logic [SW-1:0] shift_cnt;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (
        .clk      (clk),
        .rst      (rst),
        .tick_1ms (tick_1ms),
        .btn      (btn_up),
        .rise     (up_req)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_down (
        .clk      (clk),
        .rst      (rst),
        .tick_1ms (tick_1ms),
        .btn      (btn_down),
        .rise     (dn_req)
    );

    // Interlocks only matter at request time; SHIFT ignores brake/speed
    always_comb begin
        next_gear = state;
        shift_ok  = 1'b0;
        if (up_req) begin
            case (state)
                ST_P: begin next_gear = ST_R; shift_ok = brake && (speed == 8'd0); end
                ST_R: begin next_gear = ST_N; shift_ok = 1'b1; end
                ST_N: begin next_gear = ST_D; shift_ok = 1'b1; end
                default: shift_ok = 1'b0;
            endcase
        end else begin
            case (state)
                ST_D: begin next_gear = ST_N; shift_ok = 1'b1; end
                ST_N: begin next_gear = ST_R; shift_ok = (speed == 8'd0); end
                ST_R: begin next_gear = ST_P; shift_ok = (speed == 8'd0); end
                default: shift_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_P;
            target       <= ST_P;
            shift_cnt    <= '0;
            gear_char    <= GEAR_P;
            shift_busy   <= 1'b0;
            shift_reject <= 1'b0;
        end else begin
            shift_reject <= 1'b0;
            case (state)
                ST_P, ST_R, ST_N, ST_D: begin
                    gear_char <= gear_code(state);
                    if (up_req && dn_req) begin
                        shift_reject <= 1'b1;
                    end else if (up_req || dn_req) begin
                        if (shift_ok) begin
                            state      <= ST_SHIFT;
                            target     <= next_gear;
                            shift_cnt  <= '0;
                            shift_busy <= 1'b1;
                        end else begin
                            shift_reject <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (up_req || dn_req) shift_reject <= 1'b1;
                    if (tick_1ms) begin
                        if (shift_cnt >= SW'(SHIFT_MS - 1)) begin
                            state      <= target;
                            gear_char  <= gear_code(target);
                            shift_busy <= 1'b0;
                        end else begin
                            shift_cnt <= shift_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_P;
                    gear_char  <= GEAR_P;
                    shift_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed bench for gear_shift_ctrl: interlocks, debounce, shift timing and reset abort.
module tb_gear_shift_ctrl;
    import gear_shift_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1ms;
    logic       btn_up;
    logic       btn_down;
    logic       brake;
    logic [7:0] speed;
    logic [3:0] gear_char;
    logic       shift_busy;
    logic       shift_reject;

    int n_checks = 0;
    int n_fail   = 0;
    int reject_cnt = 0;
    int busy_rises = 0;
    int busy_ticks = 0;
    logic busy_prev = 1'b0;

    gear_shift_ctrl #(.DEBOUNCE_MS(20), .SHIFT_MS(200)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1ms     (tick_1ms),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .brake        (brake),
        .speed        (speed),
        .gear_char    (gear_char),
        .shift_busy   (shift_busy),
        .shift_reject (shift_reject)
    );

    always #5 clk = ~clk;

    // one tick every 4 clocks
    initial begin
        tick_1ms = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick_1ms = 1'b1;
            @(negedge clk);
            tick_1ms = 1'b0;
        end
    end

    // busy_prev is the pre-edge busy value, so ticks counted are those the DUT consumed in SHIFT
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (shift_reject) reject_cnt++;
                if (shift_busy && !busy_prev) busy_rises++;
                if (tick_1ms && busy_prev) busy_ticks++;
                busy_prev = shift_busy;
            end
        end
    end

    task automatic wait_ms(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (shift_busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (shift_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: shift_busy=%b after %0d clk, required 0", name, shift_busy, k);
        end
        wait_ms(2);
    endtask

    task automatic press(input bit up);
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        wait_ms(25);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_ms(25);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; brake = 1'b0; speed = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (gear_char !== GEAR_P) begin n_fail++; $display("FAIL reset gear_char: got %0d, required %0d", gear_char, GEAR_P); end
        n_checks++;
        if (shift_busy !== 1'b0) begin n_fail++; $display("FAIL reset shift_busy: got %b, required 0", shift_busy); end
        n_checks++;
        if (shift_reject !== 1'b0) begin n_fail++; $display("FAIL reset shift_reject: got %b, required 0", shift_reject); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_p_to_r();
        int r0 = reject_cnt;
        int b0 = busy_rises;
        int t0 = busy_ticks;
        int k  = 0;
        brake = 1'b1; speed = 8'd0;
        btn_up = 1'b1;
        while (!shift_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (shift_busy !== 1'b1) begin n_fail++; $display("FAIL p_to_r start: shift_busy=%b after %0d clk, required 1", shift_busy, k); end
        n_checks++;
        if (k < 80 || k > 83) begin n_fail++; $display("FAIL p_to_r latency: busy after %0d clk, required 80..83", k); end
        wait_ms(5);
        btn_up = 1'b0;
        wait_ms(50);
        n_checks++;
        if (gear_char !== GEAR_P) begin n_fail++; $display("FAIL p_to_r hold: gear_char=%0d during shift, required %0d", gear_char, GEAR_P); end
        wait_idle("p_to_r");
        n_checks++;
        if (gear_char !== GEAR_R) begin n_fail++; $display("FAIL p_to_r gear: got %0d, required %0d", gear_char, GEAR_R); end
        n_checks++;
        if (busy_ticks - t0 != 200) begin n_fail++; $display("FAIL p_to_r duration: busy for %0d ticks, required 200", busy_ticks - t0); end
        n_checks++;
        if (reject_cnt - r0 != 0) begin n_fail++; $display("FAIL p_to_r reject: %0d pulses, required 0", reject_cnt - r0); end
        n_checks++;
        if (busy_rises - b0 != 1) begin n_fail++; $display("FAIL p_to_r shifts: %0d, required 1", busy_rises - b0); end
    endtask

    task automatic test_brake_reject();
        int r0, b0;
        do_reset();
        brake = 1'b0; speed = 8'd0;
        r0 = reject_cnt; b0 = busy_rises;
        btn_up = 1'b1;
        wait_ms(30);
        btn_up = 1'b0;
        wait_ms(25);
        n_checks++;
        if (reject_cnt - r0 != 1) begin n_fail++; $display("FAIL brake_reject pulses: got %0d, required 1", reject_cnt - r0); end
        n_checks++;
        if (busy_rises - b0 != 0) begin n_fail++; $display("FAIL brake_reject busy: %0d shifts, required 0", busy_rises - b0); end
        n_checks++;
        if (gear_char !== GEAR_P) begin n_fail++; $display("FAIL brake_reject gear: got %0d, required %0d", gear_char, GEAR_P); end
    endtask

    task automatic test_d_to_n();
        int r0, b0;
        do_reset();
        brake = 1'b1; speed = 8'd0;
        press(1'b1); wait_idle("d_to_n p->r");
        brake = 1'b0;
        press(1'b1); wait_idle("d_to_n r->n");
        press(1'b1); wait_idle("d_to_n n->d");
        n_checks++;
        if (gear_char !== GEAR_D) begin n_fail++; $display("FAIL d_to_n setup: got %0d, required %0d", gear_char, GEAR_D); end
        speed = 8'd40;
        r0 = reject_cnt; b0 = busy_rises;
        press(1'b0); wait_idle("d_to_n d->n");
        n_checks++;
        if (gear_char !== GEAR_N) begin n_fail++; $display("FAIL d_to_n gear: got %0d, required %0d", gear_char, GEAR_N); end
        n_checks++;
        if (reject_cnt - r0 != 0) begin n_fail++; $display("FAIL d_to_n reject: %0d pulses, required 0", reject_cnt - r0); end
        press(1'b0);
        wait_ms(5);
        n_checks++;
        if (reject_cnt - r0 != 1) begin n_fail++; $display("FAIL n_to_r moving reject: %0d pulses, required 1", reject_cnt - r0); end
        n_checks++;
        if (gear_char !== GEAR_N) begin n_fail++; $display("FAIL n_to_r moving gear: got %0d, required %0d", gear_char, GEAR_N); end
        n_checks++;
        if (busy_rises - b0 != 1) begin n_fail++; $display("FAIL n_to_r moving shifts: %0d, required 1", busy_rises - b0); end
    endtask

    task automatic test_bounce();
        int r0 = reject_cnt;
        int b0 = busy_rises;
        for (int i = 0; i < 15; i++) begin
            btn_up = (i % 2 == 0);
            wait_ms(1);
        end
        btn_up = 1'b0;
        wait_ms(30);
        n_checks++;
        if (reject_cnt - r0 != 0) begin n_fail++; $display("FAIL bounce reject: %0d pulses, required 0", reject_cnt - r0); end
        n_checks++;
        if (busy_rises - b0 != 0) begin n_fail++; $display("FAIL bounce shifts: %0d, required 0", busy_rises - b0); end
        n_checks++;
        if (gear_char !== GEAR_N) begin n_fail++; $display("FAIL bounce gear: got %0d, required %0d", gear_char, GEAR_N); end
    endtask

    task automatic test_simultaneous();
        int r0 = reject_cnt;
        int b0 = busy_rises;
        btn_up = 1'b1;
        btn_down = 1'b1;
        wait_ms(30);
        btn_up = 1'b0;
        btn_down = 1'b0;
        wait_ms(25);
        n_checks++;
        if (reject_cnt - r0 != 1) begin n_fail++; $display("FAIL simultaneous reject: %0d pulses, required 1", reject_cnt - r0); end
        n_checks++;
        if (busy_rises - b0 != 0) begin n_fail++; $display("FAIL simultaneous shifts: %0d, required 0", busy_rises - b0); end
        n_checks++;
        if (gear_char !== GEAR_N) begin n_fail++; $display("FAIL simultaneous gear: got %0d, required %0d", gear_char, GEAR_N); end
    endtask

    task automatic test_reset_mid_shift();
        int k = 0;
        int b0;
        do_reset();
        brake = 1'b1; speed = 8'd0;
        btn_up = 1'b1;
        while (!shift_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        wait_ms(100);
        rst = 1'b1;
        #1;
        n_checks++;
        if (gear_char !== GEAR_P) begin n_fail++; $display("FAIL rst_mid gear: got %0d, required %0d", gear_char, GEAR_P); end
        n_checks++;
        if (shift_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b, required 0", shift_busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        b0 = busy_rises;
        wait_ms(19);
        n_checks++;
        if (shift_busy !== 1'b0 || busy_rises != b0) begin
            n_fail++;
            $display("FAIL rst_mid early: busy=%b shifts=%0d at 19 ms, required 0/0", shift_busy, busy_rises - b0);
        end
        k = 0;
        while (!shift_busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (shift_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid rearm: busy=%b after %0d extra clk, required 1", shift_busy, k); end
        n_checks++;
        if (gear_char !== GEAR_P) begin n_fail++; $display("FAIL rst_mid shift gear: got %0d, required %0d", gear_char, GEAR_P); end
    endtask

    task automatic test_back_to_back();
        int r0 = reject_cnt;
        btn_down = 1'b1;
        wait_ms(25);
        btn_down = 1'b0;
        btn_up   = 1'b0;
        wait_idle("back_to_back");
        n_checks++;
        if (reject_cnt - r0 != 1) begin n_fail++; $display("FAIL back_to_back reject: %0d pulses, required 1", reject_cnt - r0); end
        n_checks++;
        if (gear_char !== GEAR_R) begin n_fail++; $display("FAIL back_to_back gear: got %0d, required %0d", gear_char, GEAR_R); end
    endtask

    initial begin
        test_reset();
        test_p_to_r();
        test_brake_reject();
        test_d_to_n();
        test_bounce();
        test_simultaneous();
        test_reset_mid_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gear_shift_ctrl.md
GEAR_SHIFT_CTRL -- requirements
Module: gear_shift_ctrl

Interface
REQ-001 Parameter DEBOUNCE_MS, default 20, stable-input time in tick_1ms pulses before a button level is accepted.
REQ-002 Parameter SHIFT_MS, default 200, shift-in-progress duration in tick_1ms pulses.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick_1ms  input  1  one-clk-wide enable pulse, once per millisecond.
REQ-006 btn_up  input  1  raw, unsynchronised shift-toward-D button, active-high.
REQ-007 btn_down  input  1  raw, unsynchronised shift-toward-P button, active-high.
REQ-008 brake  input  1  brake pedal level, active-high, already synchronous.
REQ-009 speed  input  8  current vehicle speed, unsigned, km/h.
REQ-010 gear_char  output  4  current gear code: 3=P, 6=R, 9=N, 12=D; feeds the display stage directly.
REQ-011 shift_busy  output  1  high while a shift is in progress.
REQ-012 shift_reject  output  1  one-clk pulse when a request is refused.

Function
REQ-013 Each button SHALL pass a 2-flop synchroniser, then a debouncer that accepts a new level only after DEBOUNCE_MS consecutive tick_1ms samples at that level.
- A differing sample resets the counter to 0.
REQ-014 A request SHALL be the one-clk rising edge of a debounced level; release edges are ignored.
REQ-015 The FSM SHALL have states P, R, N, D and SHIFT; SHIFT holds the latched target gear.
- Order: P-R-N-D; up moves one step toward D, down one step toward P.
- Up in D and down in P are rejected.
REQ-016 Interlocks: leaving P requires brake=1; entering P or R requires speed==0; R-to-N and N-to-D are always allowed.
- D-to-N is always allowed.
- N-to-R requires speed==0.
REQ-017 An accepted request SHALL enter SHIFT on the next clk.
- shift_busy goes high that same cycle.
- gear_char keeps the old code throughout SHIFT.
REQ-018 SHIFT SHALL count SHIFT_MS tick_1ms pulses.
- On the count's final tick, gear_char updates to the target code on the following clk.
- shift_busy falls on that same clk.
REQ-019 A request that violates an interlock, arrives during SHIFT, or coincides with the opposite request in the same clk SHALL be rejected.
- Rejection: shift_reject pulses for exactly one clk on the cycle after the request.
- State and gear_char are unchanged.
REQ-020 Interlocks SHALL be evaluated only at request time; brake or speed changes during SHIFT do not abort it.
REQ-021 Debounce and shift counters SHALL saturate, never wrap.
- Widths: ceil(log2(param+1)) bits.
REQ-022 gear_char SHALL always hold one of the four legal codes; any illegal state recovers to P with busy=0.

Reset
REQ-023 On rst: state=P, gear_char=3, shift_busy=0, shift_reject=0.
- All counters, synchronisers and debounced levels are cleared to 0.
REQ-024 Reset asserted mid-SHIFT SHALL abandon the shift; the target is never applied.
REQ-025 After rst release, a button already held SHALL produce a request only after a full debounce interval.

Structure
REQ-026 A shared package SHALL hold gear code constants GEAR_P=3, GEAR_R=6, GEAR_N=9, GEAR_D=12 and the FSM state encoding.
- The display stage uses the same package.
REQ-027 Debounce SHALL be one sub-module, btn_debounce (synchroniser + counter + edge output), instantiated twice.

Verification
REQ-028 P, brake=1, speed=0, btn_up held 25 ms -> busy high for 200 ticks, then gear_char 3->6, no reject.
REQ-029 P, brake=0, btn_up held -> one shift_reject pulse, gear_char stays 3, busy stays 0.
REQ-030 D, speed=40, btn_down -> N (gear_char 9); second btn_down -> reject, gear_char stays 9.
REQ-031 btn_up bounces 1 ms on/off for 15 ms, then is released -> no request, no reject.
REQ-032 btn_up and btn_down reach debounced-high in the same clk -> reject pulse, no state change.
REQ-033 rst asserted 100 ms into a P-to-R shift -> gear_char=3, busy=0 immediately; after release, the still-held button needs 20 more ms before a new request.
